// File: rtl/float_pack.sv
// Shared float format definitions for the LM32 float coprocessor.
// Packed word layout is {sign, exponent, fraction}.
package float_pack;

    localparam int unsigned Nm   = 23;
    localparam int unsigned Ne   = 8;
    localparam int unsigned W    = Ne + Nm + 1;
    localparam int          BIAS = 2 ** (Ne - 1) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {Ne{1'b1}}, 1'b1, {(Nm - 1){1'b0}}};

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fmul_state_t;

    function automatic float unpack(input logic [W-1:0] word);
        float f;
        f = word;
        return f;
    endfunction

    function automatic logic [W-1:0] pack(input float f);
        return f;
    endfunction

    // Denormals are flushed, so a zero exponent field means zero.
    function automatic logic is_zero(input float f);
        return (f.e == '0);
    endfunction

    function automatic logic is_inf(input float f);
        return (&f.e);
    endfunction

endpackage

// File: rtl/float_mul_seq.sv
// Iterative float multiplier: shift-add mantissa product, one bit per cycle,
// then normalise, truncate and repack.
module float_mul_seq
    import float_pack::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int unsigned CW = $clog2(Nm + 1);
    localparam int unsigned EW = Ne + 2;

    fmul_state_t   r_state, w_state_d;
    logic          r_sign;
    logic [Ne-1:0] r_ea, r_eb;
    logic [Nm:0]   r_ma, r_mb, r_acc;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_result;

    float            w_fa, w_fb;
    logic            w_sign, w_zero, w_inf, w_special;
    logic [W-1:0]    w_special_res;
    logic [Nm+1:0]   w_sum;
    logic            w_top;
    logic [Nm-1:0]   w_frac;
    logic signed [EW-1:0] w_exp;
    logic [W-1:0]    w_norm_res;

    assign w_fa      = unpack(a);
    assign w_fb      = unpack(b);
    assign w_sign    = w_fa.s ^ w_fb.s;
    assign w_zero    = is_zero(w_fa) | is_zero(w_fb);
    assign w_inf     = is_inf(w_fa) | is_inf(w_fb);
    assign w_special = w_zero | w_inf;

    always_comb begin
        w_special_res = pack('{s: w_sign, e: '0, m: '0});
        if (w_inf && w_zero) begin
            w_special_res = QNAN;
        end else if (w_inf) begin
            w_special_res = pack('{s: w_sign, e: '1, m: '0});
        end
    end

    // Adder output keeps the carry; it is shifted straight back into acc.
    assign w_sum = {1'b0, r_acc} + (r_mb[0] ? {1'b0, r_ma} : '0);

    // Product P = {acc, mb}; top bit set means the product is in [2,4).
    assign w_top  = r_acc[Nm];
    assign w_frac = w_top ? r_acc[Nm-1:0] : {r_acc[Nm-2:0], r_mb[Nm]};
    assign w_exp  = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - $signed(EW'(BIAS))
                  + $signed({{(EW - 1){1'b0}}, w_top});

    always_comb begin
        w_norm_res = {r_sign, w_exp[Ne-1:0], w_frac};
        if (w_exp >= $signed(EW'(2 ** Ne - 1))) begin
            w_norm_res = pack('{s: r_sign, e: '1, m: '0});
        end else if (w_exp <= 0) begin
            w_norm_res = pack('{s: r_sign, e: '0, m: '0});
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_d = w_special ? DONE : MUL;
            MUL:  if (r_cnt == CW'(Nm)) w_state_d = NORM;
            NORM: w_state_d = DONE;
            DONE: w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= w_sign;
                        r_ea   <= w_fa.e;
                        r_eb   <= w_fb.e;
                        r_ma   <= {1'b1, w_fa.m};
                        r_mb   <= {1'b1, w_fb.m};
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        if (w_special) r_result <= w_special_res;
                    end
                end
                MUL: begin
                    r_acc <= w_sum[Nm+1:1];
                    r_mb  <= {w_sum[0], r_mb[Nm:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                NORM: r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule
